// File: rtl/jtframe_mouse_ps2.sv
// PS/2 mouse receiver: filters ps2_clk, deserialises 11-bit frames and
// assembles 3-byte stream packets into signed 9-bit deltas plus buttons.
module jtframe_mouse_ps2 #(
  parameter int unsigned FILT   = 8,
  parameter int unsigned TOUT_W = 16,
  parameter bit          SAT    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] mouse_dx,
  output logic [8:0] mouse_dy,
  output logic [2:0] mouse_but,
  output logic       mouse_st,
  output logic       frame_err
);

  localparam int unsigned CW = (FILT > 1) ? $clog2(FILT + 1) : 1;

  typedef enum logic [1:0] {B0, B1, B2} pkt_t;

  pkt_t              state, state_nx;
  logic              clk_s1, clk_s2, dat_s1, dat_s2;
  logic              filt_clk;
  logic [CW-1:0]     filt_cnt;
  logic              fall;
  logic [3:0]        bit_cnt;
  logic [7:0]        sh;
  logic              par;
  logic              frame_ok, frame_bad;
  logic              byte_ok;
  logic [TOUT_W-1:0] tout_cnt;
  logic              tout_active, tout_fire;
  logic              load_hdr, load_x, load_out, discard;
  logic              xs, ys, xo, yo;
  logic [2:0]        but_l;
  logic [7:0]        x_byte;
  logic [8:0]        dx_nx, dy_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 != filt_clk) begin
      if (filt_cnt == CW'(FILT - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  // The fall is flagged in the cycle the filter is about to toggle, so data is sampled then
  assign fall        = filt_clk & ~clk_s2 & (filt_cnt == CW'(FILT - 1));
  assign frame_ok    = (^{sh, par}) & dat_s2;
  assign frame_bad   = fall & (bit_cnt == 4'd10) & ~frame_ok;
  assign tout_active = (bit_cnt != 4'd0) || (state != B0);
  assign tout_fire   = ~fall & tout_active & (tout_cnt == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      sh       <= '0;
      par      <= 1'b0;
      byte_ok  <= 1'b0;
      tout_cnt <= '0;
    end else begin
      byte_ok <= 1'b0;
      if (fall) begin
        tout_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (!dat_s2) bit_cnt <= 4'd1;
        end else if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          byte_ok <= frame_ok;
        end else begin
          if (bit_cnt <= 4'd8) sh <= {dat_s2, sh[7:1]};
          else                 par <= dat_s2;
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (tout_fire) begin
        bit_cnt  <= '0;
        tout_cnt <= '0;
      end else if (tout_active) begin
        tout_cnt <= tout_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= B0;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_hdr = 1'b0;
    load_x   = 1'b0;
    load_out = 1'b0;
    discard  = 1'b0;
    if (tout_fire) begin
      state_nx = B0;
    end else if (frame_bad) begin
      state_nx = B0;
    end else if (byte_ok) begin
      case (state)
        B0: begin
          if (sh[3]) begin
            load_hdr = 1'b1;
            state_nx = B1;
          end else begin
            discard = 1'b1;
          end
        end
        B1: begin
          load_x   = 1'b1;
          state_nx = B2;
        end
        B2: begin
          load_out = 1'b1;
          state_nx = B0;
        end
        default: state_nx = B0;
      endcase
    end
  end

  always_comb begin
    dx_nx = {xs, x_byte};
    dy_nx = {ys, sh};
    if (SAT && xo) dx_nx = xs ? 9'h100 : 9'h0FF;
    if (SAT && yo) dy_nx = ys ? 9'h100 : 9'h0FF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      but_l     <= '0;
      xs        <= 1'b0;
      ys        <= 1'b0;
      xo        <= 1'b0;
      yo        <= 1'b0;
      x_byte    <= '0;
      mouse_dx  <= '0;
      mouse_dy  <= '0;
      mouse_but <= '0;
      mouse_st  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mouse_st  <= load_out;
      frame_err <= frame_bad | tout_fire | discard;
      if (load_hdr) begin
        but_l <= sh[2:0];
        xs    <= sh[4];
        ys    <= sh[5];
        xo    <= sh[6];
        yo    <= sh[7];
      end
      if (load_x) x_byte <= sh;
      if (load_out) begin
        mouse_dx  <= dx_nx;
        mouse_dy  <= dy_nx;
        mouse_but <= but_l;
      end
    end
  end

endmodule

// File: doc/jtframe_mouse_ps2.md
Name: jtframe_mouse_ps2

Overview:
- PS/2 mouse receiver that sits directly upstream of the paddle/position stages.
- Deserialises the raw ps2_clk/ps2_data lines, assembles standard 3-byte stream-mode packets, and emits signed 9-bit X/Y deltas, button state and a one-cycle mouse_st strobe.
- Host-to-device commands (e.g. enable reporting) are handled by a separate block and are out of scope.

Parameters:
- FILT, 8, consecutive identical synchronised samples required before filtered ps2_clk changes state.
- TOUT_W, 16, width of the inactivity timeout counter; timeout fires when the counter reaches 2^TOUT_W-1.
- SAT, 1, when 1 an overflow flag saturates the delta to +255/-256; when 0 overflow flags are ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock line (asynchronous)
- ps2_data  in  1  raw PS/2 data line (asynchronous)
- mouse_dx  out  9  signed X delta, positive = right
- mouse_dy  out  9  signed Y delta, positive = up (device convention, not inverted)
- mouse_but  out  3  {middle,right,left} buttons from byte0[2:0]
- mouse_st  out  1  one-cycle strobe: new dx/dy/but valid
- frame_err  out  1  one-cycle pulse on bad frame, timeout or discarded sync byte

Behaviour:
- Reset: all outputs 0; bit counter 0; packet index B0; filter state high; timeout counter 0.
- Input sync: two flops on each of ps2_clk and ps2_data.
- Clock filter:
  - Filtered clock toggles only after FILT consecutive samples differing from its current value.
  - Any mismatch reloads the filter count.
  - Fall event = filtered clock 1->0; data is sampled in the same cycle from synchronised ps2_data.
- Frame format: 11 bits — start(0), 8 data LSB first, odd parity, stop(1).
  - Bit counter runs 0..10.
  - Fall with counter=0 and data=1 is ignored (no frame started).
- Frame check at bit 10:
  - Valid = start==0, parity odd over data+parity, stop==1.
  - Invalid: byte dropped, packet index -> B0, frame_err pulse 1 cycle later.
  - Counter returns to 0 in either case.
- Timeout:
  - Counter clears on every fall event.
  - Increments while bit counter!=0 or packet index!=B0.
  - At max: bit counter and packet index cleared, counter cleared, frame_err pulses.
- Packet FSM (advances on each valid byte, 1 cycle after stop sample):
  - B0: accept only if byte[3]==1. Latch buttons [2:0], xs=byte[4], ys=byte[5], xo=byte[6], yo=byte[7] -> B1. If byte[3]==0: discard, stay B0, frame_err pulse.
  - B1: latch X byte -> B2.
  - B2: Y byte; compute outputs -> B0.
- Arithmetic:
  - dx = {xs, X}, dy = {ys, Y} (9-bit two's complement).
  - If SAT and xo: dx = xs ? 9'h100 : 9'h0FF. Y likewise with yo.
- Output timing:
  - mouse_dx/dy/but registered; update and mouse_st assert exactly 2 clk after the cycle the byte-2 stop bit is sampled.
  - mouse_st high for exactly 1 cycle.
  - Outputs hold between strobes.
- Simultaneous events: a fall event in the same cycle the timeout reaches max takes priority; the timeout is cancelled.
- Reset mid-frame or mid-packet: partial data discarded; no mouse_st or frame_err generated.

Test Plan:
- Bytes 0x08,0x05,0x03, 60 us bit period -> single mouse_st; dx=9'h005, dy=9'h003, but=3'b000.
- Bytes 0x39,0xFB,0xFE -> dx=9'h1FB (-5), dy=9'h1FE (-2), but=3'b001.
- Bytes 0x48,0x10,0x00 with SAT=1 -> dx=9'h0FF, dy=0. Same stimulus with 0x58 -> dx=9'h100.
- Byte1 sent with wrong parity -> frame_err pulse, no mouse_st; following good packet 0x0A,0x01,0x01 decodes, but=3'b010.
- Leading byte 0x00, then 0x08,0x02,0x02 -> one frame_err for the discard, then mouse_st with dx=2, dy=2.
- Byte0 only, then idle > 2^TOUT_W cycles -> frame_err, index back to B0; next full packet decodes correctly.
- ps2_clk glitches low for FILT-1 cycles -> ignored, bit counter unchanged.
